// File: rtl/rot_count_uart_reporter_pkg.sv
// Shared types, ASCII constants and helpers for the rotary count UART reporter.
package rot_count_uart_reporter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    DIR_CC  = 1'b0,
    DIR_CCW = 1'b1
  } dir_t;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int MSG_LEN = 5;
  localparam int IDX_W   = 3;

  // Uppercase hex digit for one nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
// Each bit is held BAUD_DIV clocks. The first bit goes out one clock after the
// start request is sampled; done is high during the last clock of the stop bit.
module uart_tx_byte
  import rot_count_uart_reporter_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic [9:0]       frame;
  logic             pending;
  logic             active;
  logic [3:0]       bits_left;
  logic [CNT_W-1:0] baud_cnt;

  // Frame load, bit-period down-counter and shift-out; requests while busy are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= '1;
      pending   <= 1'b0;
      active    <= 1'b0;
      bits_left <= '0;
      baud_cnt  <= '0;
      tx        <= 1'b1;
    end else if (pending) begin
      pending   <= 1'b0;
      active    <= 1'b1;
      tx        <= frame[0];
      frame     <= {1'b1, frame[9:1]};
      bits_left <= 4'd9;
      baud_cnt  <= BAUD_LAST;
    end else if (active) begin
      if (baud_cnt == '0) begin
        if (bits_left == '0) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx        <= frame[0];
          frame     <= {1'b1, frame[9:1]};
          bits_left <= bits_left - 4'd1;
          baud_cnt  <= BAUD_LAST;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end else if (start) begin
      frame   <= {1'b1, data, 1'b0};
      pending <= 1'b1;
    end
  end

  assign done = active && (baud_cnt == '0) && (bits_left == '0);

endmodule

// File: rtl/rot_count_uart_reporter.sv
// Rotary position counter that reports every change over UART as "<dir><HH>\r\n".
// Build option ROT_COUNT_SATURATE_EN: when defined the count clamps at 0x00/0xFF
// instead of wrapping; an event at the limit still triggers a report.
//
// state | meaning
// IDLE  | no message in flight; waits for dirty, then snapshots count/direction
// SEND  | one-cycle start request for the current message byte
// WAIT  | byte on the line; advances index or returns to IDLE after the last byte
module rot_count_uart_reporter
  import rot_count_uart_reporter_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115_200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cc_pulse,
  input  logic       ccw_pulse,
  output logic [7:0] count,
  output logic       busy,
  output logic       uart_tx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  state_t           state, state_nx;
  dir_t             dir, msg_dir;
  logic             dirty;
  logic [7:0]       count_nx;
  logic [7:0]       msg_val;
  logic [7:0]       tx_data;
  logic [IDX_W-1:0] idx;
  logic             ev_cc, ev_ccw, ev_any;
  logic             snap, tx_start, tx_done, idx_inc;

  // Simultaneous pulses cancel out and are not an event.
  assign ev_cc  = cc_pulse & ~ccw_pulse;
  assign ev_ccw = ccw_pulse & ~cc_pulse;
  assign ev_any = ev_cc | ev_ccw;

  // Next count value: wrap or clamp depending on build option.
  always_comb begin
    count_nx = count;
    if (ev_cc) begin
`ifdef ROT_COUNT_SATURATE_EN
      if (count != 8'hFF) count_nx = count + 8'd1;
`else
      count_nx = count + 8'd1;
`endif
    end else if (ev_ccw) begin
`ifdef ROT_COUNT_SATURATE_EN
      if (count != 8'h00) count_nx = count - 8'd1;
`else
      count_nx = count - 8'd1;
`endif
    end
  end

  // Position count and last direction track every accepted event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'h00;
      dir   <= DIR_CC;
    end else if (ev_any) begin
      count <= count_nx;
      dir   <= ev_cc ? DIR_CC : DIR_CCW;
    end
  end

  // Dirty flag: a new event on the snapshot edge wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= 1'b0;
    end else if (ev_any) begin
      dirty <= 1'b1;
    end else if (snap) begin
      dirty <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_nx = state;
    snap     = 1'b0;
    tx_start = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dirty) begin
          snap     = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_start = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (idx == IDX_LAST) begin
            state_nx = ST_IDLE;
          end else begin
            idx_inc  = 1'b1;
            state_nx = ST_SEND;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Message snapshot and byte index; later events never touch the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_val <= 8'h00;
      msg_dir <= DIR_CC;
      idx     <= '0;
    end else if (snap) begin
      msg_val <= count;
      msg_dir <= dir;
      idx     <= '0;
    end else if (idx_inc) begin
      idx <= idx + 1'b1;
    end
  end

  // Byte selection for the current message index.
  always_comb begin
    tx_data = ASCII_LF;
    case (idx)
      3'd0:    tx_data = (msg_dir == DIR_CCW) ? ASCII_MINUS : ASCII_PLUS;
      3'd1:    tx_data = hex_ascii(msg_val[7:4]);
      3'd2:    tx_data = hex_ascii(msg_val[3:0]);
      3'd3:    tx_data = ASCII_CR;
      default: tx_data = ASCII_LF;
    endcase
  end

  assign busy = (state != ST_IDLE);

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_data),
    .tx   (uart_tx),
    .done (tx_done)
  );

endmodule
